// File: rtl/bit_serial_sub_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial subtractor sequencer.
// master drives operands and result acceptance; slave is the sequencer side.
interface bit_serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface

// File: rtl/bit_serial_sub_ctrl.sv
// Computes a - b - bin one bit per clock through a single full_subtractor cell.
// Result valid WIDTH cycles after accept; HOLD persists while out_ready is low.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module bit_serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  bit_serial_sub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             fs_d, fs_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (brw_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SHIFT;
      SHIFT:   if (last_bit)     state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == HOLD);
    bus.busy      = (state_q != IDLE);
    bus.diff      = diff_q;
    bus.bout      = bout_q;
    bus.ovf       = ovf_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    brw_d   = brw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
        end
      end
      SHIFT: begin
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        brw_d  = fs_bout;
        // Counter stops at WIDTH-1 so it never wraps when WIDTH is a power of two
        if (!last_bit) cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d = {fs_d, res_q[WIDTH-1:1]};
          bout_d = fs_bout;
          ovf_d  = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Directed and random bench for bit_serial_sub_ctrl with a result scoreboard.
module tb_bit_serial_sub_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  bit_serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    exp_t e;
    full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.ovf  = ov;
    return e;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_diff"}, bus.diff, 0);
    check({tag, "_bout"}, bus.bout, 0);
    check({tag, "_ovf"}, bus.ovf, 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, output int acc);
    int n;
    n = 0;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait_bound", n < 50, 1);
    @(posedge clk); #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    check("in_ready_after_accept", bus.in_ready, 0);
  endtask

  task automatic collect(input int stall, input bit pulse, input int acc);
    int   n;
    exp_t e;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_wait_bound", n < 100, 1);
    check("latency", cyc - acc, W);
    check("scoreboard_nonempty", sb.size() != 0, 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      if (pulse) begin
        bus.in_valid = ~bus.in_valid;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.bin = 1'($urandom);
      end
      check("hold_diff", bus.diff, e.diff);
      check("hold_bout", bus.bout, e.bout);
      check("hold_ovf", bus.ovf, e.ovf);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    if (pulse) bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("diff", bus.diff, e.diff);
    check("bout", bus.bout, e.bout);
    check("ovf", bus.ovf, e.ovf);
    check("out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    check("release_busy", bus.busy, 0);
  endtask

  initial begin
    int acc, prev_acc;
    logic [W-1:0] ra, rb;
    logic rbin;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;

    send(8'h5A, 8'h3C, 1'b0, acc);
    sb.push_back(mk(8'h1E, 1'b0, 1'b0));
    collect(0, 1'b0, acc);

    send(8'h00, 8'h01, 1'b0, acc);
    sb.push_back(mk(8'hFF, 1'b1, 1'b0));
    collect(0, 1'b0, acc);

    send(8'h80, 8'h01, 1'b0, acc);
    sb.push_back(mk(8'h7F, 1'b0, 1'b1));
    collect(0, 1'b0, acc);

    send(8'h7F, 8'hFF, 1'b1, acc);
    sb.push_back(mk(8'h7F, 1'b1, 1'b0));
    collect(0, 1'b0, acc);

    // Backpressure with stray in_valid pulses that must be ignored
    send(8'h33, 8'h11, 1'b0, acc);
    sb.push_back(mk(8'h22, 1'b0, 1'b0));
    collect(5, 1'b1, acc);

    // in_valid held through the release edge is only taken one cycle later
    send(8'h05, 8'h07, 1'b0, acc);
    sb.push_back(mk(8'hFE, 1'b1, 1'b0));
    bus.a = 8'h44;
    bus.b = 8'h04;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    collect(0, 1'b0, acc);
    @(posedge clk); #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    check("accept_after_release_busy", bus.busy, 1);
    sb.push_back(mk(8'h40, 1'b0, 1'b0));
    collect(0, 1'b0, acc);

    send(8'hF0, 8'h0F, 1'b0, acc);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("mid_reset");
    rst_n = 1'b1;
    send(8'h10, 8'h01, 1'b0, acc);
    sb.push_back(mk(8'h0F, 1'b0, 1'b0));
    collect(0, 1'b0, acc);

    prev_acc = 0;
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, acc);
      if (k > 0) check("op_spacing", (acc - prev_acc) >= (W + 2), 1);
      prev_acc = acc;
      sb.push_back(model(ra, rb, rbin));
      collect(int'($urandom_range(0, 3)), 1'b0, acc);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
